seq_magnitude_comparator: RTL and testbench

Multi-cycle, parametrised magnitude comparator that accepts two WIDTH-bit operands over a valid/ready handshake. It compares them most-significant digit first, DIGIT bits per cycle, and stops at the first differing digit. It returns a one-hot greater/equal/less result over a second valid/ready handshake. Signed and unsigned modes are selected per transaction. It is the sequential, wide-operand successor to the team's 4-bit combinational comparator, for use where a full-width single-cycle compare would close poorly on timing.

---
 rtl/seq_magnitude_comparator_pkg.sv | 18 +
 rtl/seq_magnitude_comparator_if.sv | 31 +++
 rtl/seq_magnitude_comparator_digit_compare.sv | 17 +
 rtl/seq_magnitude_comparator.sv | 99 +++++++++
 tb/tb_seq_magnitude_comparator.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
//   state_t        : controller state encoding (IDLE, COMPARE, DONE)
//   RES_GT/EQ/LT   : bit positions of the one-hot result vector
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  localparam int unsigned RES_GT = 2;
  localparam int unsigned RES_EQ = 1;
  localparam int unsigned RES_LT = 0;

  typedef logic [2:0] result_t;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake bundle for seq_magnitude_comparator.
//   in_valid/in_ready   : operand handshake (a, b, signed_mode)
//   out_valid/out_ready : result handshake (gt, eq, lt, one-hot)
// modport master : producer/consumer side (testbench or upstream logic)
// modport slave  : the comparator itself
interface seq_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, gt, eq, lt
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, gt, eq, lt
  );

endinterface

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice.
//   i_a, i_b : digit of operand A / B
//   o_gt     : i_a > i_b
//   o_lt     : i_a < i_b   (neither set means the digits are equal)
module digit_compare #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_gt,
  output logic             o_lt
);

  assign o_gt = (i_a > i_b);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks operands MSB digit first, DIGIT
// bits per cycle, stopping at the first differing digit.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : seq_magnitude_comparator_if.slave (operand and result handshakes)
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  seq_magnitude_comparator_if.slave     bus
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IDX_W-1:0]   r_idx;
  result_t            r_res;

  logic [WIDTH-1:0]   w_flip;
  logic [31:0]        w_base;
  logic [DIGIT-1:0]   w_dig_a;
  logic [DIGIT-1:0]   w_dig_b;
  logic               w_gt;
  logic               w_lt;

  // Inverting the sign bit maps two's-complement ordering onto unsigned
  // ordering, so the digit walk itself is always unsigned.
  assign w_flip  = {bus.signed_mode, {(WIDTH-1){1'b0}}};

  assign w_base  = 32'(r_idx) * DIGIT;
  assign w_dig_a = r_a[w_base +: DIGIT];
  assign w_dig_b = r_b[w_base +: DIGIT];

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .i_a  (w_dig_a),
    .i_b  (w_dig_b),
    .o_gt (w_gt),
    .o_lt (w_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a ^ w_flip;
            r_b     <= bus.b ^ w_flip;
            r_idx   <= IDX_W'(NUM_DIGITS - 1);
            r_res   <= '0;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_gt) begin
            r_res[RES_GT] <= 1'b1;
            r_state       <= DONE;
          end else if (w_lt) begin
            r_res[RES_LT] <= 1'b1;
            r_state       <= DONE;
          end else if (r_idx == '0) begin
            r_res[RES_EQ] <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_res   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.gt        = r_res[RES_GT];
  assign bus.eq        = r_res[RES_EQ];
  assign bus.lt        = r_res[RES_LT];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator at three parametrisations:
//   dut 0: WIDTH=16 DIGIT=4, dut 1: WIDTH=8 DIGIT=8, dut 2: WIDTH=32 DIGIT=2
module tb_seq_magnitude_comparator;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    logic [2:0]  res;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc      [3];
  bit   prev_ov  [3];
  logic [2:0] cur [3];
  exp_t q [3][$];

  seq_magnitude_comparator_if #(.WIDTH(16)) bus16 ();
  seq_magnitude_comparator_if #(.WIDTH(8))  bus8  ();
  seq_magnitude_comparator_if #(.WIDTH(32)) bus32 ();

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  seq_magnitude_comparator #(.WIDTH(8),  .DIGIT(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  seq_magnitude_comparator #(.WIDTH(32), .DIGIT(2)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [31:0] a, input logic [31:0] b, input bit s);
    case (d)
      0: begin bus16.in_valid = v; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.signed_mode = s; end
      1: begin bus8.in_valid  = v; bus8.a  = a[7:0];  bus8.b  = b[7:0];  bus8.signed_mode  = s; end
      2: begin bus32.in_valid = v; bus32.a = a;       bus32.b = b;       bus32.signed_mode = s; end
      default: ;
    endcase
  endtask

  function automatic bit rdy(input int d);
    case (d)
      0:       return bus16.in_ready;
      1:       return bus8.in_ready;
      default: return bus32.in_ready;
    endcase
  endfunction

  // Present one transaction, wait (bounded) for acceptance, record expectation.
  task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input bit s,
                      input logic [2:0] res, input int lat, input bit track);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(d, 1'b1, a, b, s);
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      if (rdy(d)) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d accept timeout", d);
    end else if (track) begin
      q[d].push_back('{res, lat});
    end
    @(negedge clk);
    drive(d, 1'b0, a, b, s);
  endtask

  // Capture accept edges for latency measurement.
  always @(posedge clk) begin
    cyc++;
    if (bus16.in_valid && bus16.in_ready) acc[0] = cyc;
    if (bus8.in_valid  && bus8.in_ready)  acc[1] = cyc;
    if (bus32.in_valid && bus32.in_ready) acc[2] = cyc;
  end

  task automatic mon(input int d, input logic ov, input logic [2:0] r);
    exp_t e;
    if (ov && !prev_ov[d]) begin
      if (q[d].size() == 0) begin
        n_checks++;
        n_fail++;
        cur[d] = r;
        $display("FAIL dut%0d unexpected result: got %0b expected none", d, r);
      end else begin
        e = q[d].pop_front();
        cur[d] = e.res;
        chk($sformatf("dut%0d result", d), 32'(r), 32'(e.res));
        chk($sformatf("dut%0d latency", d), 32'(cyc - acc[d]), 32'(e.lat));
      end
    end else if (ov) begin
      chk($sformatf("dut%0d result_hold", d), 32'(r), 32'(cur[d]));
    end else begin
      chk($sformatf("dut%0d idle_zero", d), 32'(r), 32'd0);
    end
    prev_ov[d] = ov;
  endtask

  always @(negedge clk) begin
    mon(0, bus16.out_valid, {bus16.gt, bus16.eq, bus16.lt});
    mon(1, bus8.out_valid,  {bus8.gt,  bus8.eq,  bus8.lt});
    mon(2, bus32.out_valid, {bus32.gt, bus32.eq, bus32.lt});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t v16 [9];
  bit   seen;

  initial begin
    v16[0] = '{32'h12F0, 32'h12F0, 1'b0, R_EQ, 4};
    v16[1] = '{32'h8000, 32'h7FFF, 1'b0, R_GT, 1};
    v16[2] = '{32'h8000, 32'h7FFF, 1'b1, R_LT, 1};
    v16[3] = '{32'h1234, 32'h1235, 1'b0, R_LT, 4};
    v16[4] = '{32'hFFFE, 32'hFFFF, 1'b1, R_LT, 4};
    v16[5] = '{32'h0100, 32'h00FF, 1'b0, R_GT, 2};
    v16[6] = '{32'hFFFF, 32'h0001, 1'b1, R_LT, 1};
    v16[7] = '{32'h00F0, 32'h00F3, 1'b1, R_LT, 4};
    v16[8] = '{32'h0005, 32'hFFFB, 1'b1, R_GT, 1};

    for (int d = 0; d < 3; d++) drive(d, 1'b0, '0, '0, 1'b0);
    bus16.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    bus32.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset in_ready",  32'(bus16.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus16.out_valid), 32'd0);
    chk("reset result",    32'({bus16.gt, bus16.eq, bus16.lt}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      send(0, v16[i].a, v16[i].b, v16[i].s, v16[i].res, v16[i].lat, 1'b1);

    // Backpressure: result must hold, new operands must wait.
    repeat (8) @(negedge clk);
    bus16.out_ready = 1'b0;
    send(0, 32'h1234, 32'h1235, 1'b0, R_LT, 4, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      if (bus16.out_valid) seen = 1'b1;
    end
    chk("bp out_valid seen", 32'(seen), 32'd1);
    drive(0, 1'b1, 32'h00A0, 32'h00A1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp in_ready",  32'(bus16.in_ready),  32'd0);
      chk("bp out_valid", 32'(bus16.out_valid), 32'd1);
    end
    bus16.out_ready = 1'b1;
    @(negedge clk);
    chk("bp idle in_ready",  32'(bus16.in_ready),  32'd1);
    chk("bp idle out_valid", 32'(bus16.out_valid), 32'd0);
    @(posedge clk);
    chk("bp accept", 32'(bus16.in_ready), 32'd1);
    q[0].push_back('{R_LT, 4});
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    repeat (8) @(negedge clk);

    // Reset mid-COMPARE: transaction discarded, nothing emitted.
    send(0, 32'h1234, 32'h1234, 1'b0, R_EQ, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst mid in_ready",  32'(bus16.in_ready),  32'd1);
    chk("rst mid out_valid", 32'(bus16.out_valid), 32'd0);
    chk("rst mid result",    32'({bus16.gt, bus16.eq, bus16.lt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Other parametrisations.
    send(1, 32'h05, 32'h03, 1'b0, R_GT, 1, 1'b1);
    send(1, 32'h80, 32'h7F, 1'b1, R_LT, 1, 1'b1);
    send(2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, R_EQ, 16, 1'b1);
    send(2, 32'h00000001, 32'h00000000, 1'b0, R_GT, 16, 1'b1);

    for (int i = 0; i < 100 && (q[0].size() + q[1].size() + q[2].size()) != 0; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain dut0", 32'(q[0].size()), 32'd0);
    chk("drain dut1", 32'(q[1].size()), 32'd0);
    chk("drain dut2", 32'(q[2].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
